// File: rtl/mode_req_arbiter_pkg.sv
// Shared types, command codes and the command-to-mode decoder used by the
// mode-change arbiter and its round-robin sub-block.
package mode_arb_pkg;

  // Sequencer states. Encoding 2'b11 is deliberately left unused and is
  // recovered to IDLE by the FSM default branch.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    RESP  = 2'b10
  } state_e;

  // Security modes, ordered so that a numerically larger value is a more
  // privileged mode (escalation check relies on this ordering).
  typedef enum logic [1:0] {
    MODE_SAFE = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_HIGH = 2'd3
  } mode_e;

  localparam logic [2:0] CMD_HIGH = 3'h3;
  localparam logic [2:0] CMD_MID  = 3'h4;
  localparam logic [2:0] CMD_LOW  = 3'h5;
  localparam logic [2:0] CMD_LOCK = 3'h7;

  localparam int CMD_W = 3;

  // Any code that is not an explicit mode request collapses to MODE_SAFE,
  // which is always legal. CMD_LOCK also decodes to MODE_SAFE here; the
  // FSM intercepts it before the decoded target is ever applied.
  function automatic mode_e decode_cmd(input logic [2:0] code);
    case (code)
      CMD_HIGH: return MODE_HIGH;
      CMD_MID:  return MODE_MID;
      CMD_LOW:  return MODE_LOW;
      default:  return MODE_SAFE;
    endcase
  endfunction

endpackage

// File: rtl/mode_req_arbiter_if.sv
// Request/response bundle between the requesting agents and the arbiter.
// The master side raises requests; the slave side (arbiter) answers them and
// publishes the current mode/lock state to the gated datapath.
interface mode_req_arbiter_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] cmd;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   err;
  logic [1:0]           mode;
  logic                 locked;
  logic                 busy;

  modport master (
    output req,
    output cmd,
    input  ack,
    input  err,
    input  mode,
    input  locked,
    input  busy
  );

  modport slave (
    input  req,
    input  cmd,
    output ack,
    output err,
    output mode,
    output locked,
    output busy
  );

endinterface

// File: rtl/mode_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first active requester at or
// after ptr_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  // Candidate index and its request bit for each offset from the pointer.
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      // Modular add kept one bit wider so the wrap compare cannot overflow.
      assign sum          = {1'b0, ptr_i} + (IDX_W + 1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W + 1)'(NUM_REQ))
                            ? IDX_W'(sum - (IDX_W + 1)'(NUM_REQ))
                            : IDX_W'(sum);
      assign cand_req[gi] = req_i[cand_idx[gi]];
    end
  endgenerate

  // Scan offsets from farthest to nearest so the nearest active one wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/mode_req_arbiter.sv
// Mode-change request arbiter. Serves one request per three-cycle
// IDLE -> CHECK -> RESP transaction, owns the shared security-mode register
// and the sticky lock flag. Only PRIV_IDX may raise the mode or lock it.
module mode_req_arbiter
  import mode_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int PRIV_IDX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  mode_req_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] PRIV = IDX_W'(PRIV_IDX);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

  // Registered state.
  state_e             state_q;
  mode_e              mode_q;
  logic               locked_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] err_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic [2:0]         cmd_q;

  // Next-state values produced by the CHECK evaluation.
  mode_e              mode_d;
  logic               locked_d;
  logic               accept_d;
  mode_e              target;

  // Arbiter results.
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_ptr_d;

  // Per-requester command slices and the one-hot of the latched winner.
  logic [2:0]         cmd_arr [NUM_REQ];
  logic [NUM_REQ-1:0] win_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign cmd_arr[gi]    = bus.cmd[CMD_W*gi +: CMD_W];
      assign win_onehot[gi] = (win_q == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i         (bus.req),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Pointer moves to the requester just after the winner, wrapping.
  always_comb begin
    rr_ptr_d = (grant_idx == LAST) ? '0 : grant_idx + IDX_W'(1);
  end

  // Policy evaluation of the latched command, highest priority first:
  // lock blocks everything, LOCK is privileged, escalation is privileged.
  always_comb begin
    target   = decode_cmd(cmd_q);
    mode_d   = mode_q;
    locked_d = locked_q;
    accept_d = 1'b0;
    if (locked_q) begin
      accept_d = 1'b0;
    end else if (cmd_q == CMD_LOCK) begin
      if (win_q == PRIV) begin
        locked_d = 1'b1;
        accept_d = 1'b1;
      end
    end else if ((target > mode_q) && (win_q != PRIV)) begin
      accept_d = 1'b0;
    end else begin
      mode_d   = target;
      accept_d = 1'b1;
    end
  end

  // Transaction sequencer with registered outputs; unknown encodings fall
  // back to IDLE without touching mode, lock or the response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SAFE;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      rr_ptr_q <= '0;
      win_q    <= '0;
      cmd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          err_q <= '0;
          if (grant_valid) begin
            win_q    <= grant_idx;
            cmd_q    <= cmd_arr[grant_idx];
            rr_ptr_q <= rr_ptr_d;
            state_q  <= CHECK;
            busy_q   <= 1'b1;
          end
        end
        CHECK: begin
          mode_q   <= mode_d;
          locked_q <= locked_d;
          ack_q    <= accept_d ? win_onehot : '0;
          err_q    <= accept_d ? '0 : win_onehot;
          state_q  <= RESP;
          busy_q   <= 1'b1;
        end
        RESP: begin
          ack_q   <= '0;
          err_q   <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          ack_q   <= '0;
          err_q   <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.mode   = mode_q;
  assign bus.locked = locked_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mode_req_arbiter.sv
// Directed bench for mode_req_arbiter: single requests, escalation policy,
// simultaneous round-robin service, lock and reset during a transaction.
module tb_mode_req_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mode_req_arbiter_if #(.NUM_REQ(2)) bus ();

  mode_req_arbiter #(
    .NUM_REQ  (2),
    .PRIV_IDX (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated request: raise at cycle N, expect busy at N+1, the pulse
  // and new mode/lock at N+2, and idle again at N+3.
  task automatic txn(input int idx, input logic [2:0] c, input logic exp_ack,
                     input logic [1:0] exp_mode, input logic exp_lock, input string tag);
    logic [1:0] bit_i;
    bit_i = 2'b01 << idx;
    @(negedge clk);
    bus.req[idx]         = 1'b1;
    bus.cmd[3*idx +: 3]  = c;
    @(negedge clk);
    chk({tag, ".busy1"},  32'(bus.busy), 32'd1);
    chk({tag, ".quiet1"}, 32'(bus.ack | bus.err), 32'd0);
    @(negedge clk);
    $display("txn %s: req%0d cmd=%0h ack=%b err=%b mode=%0d locked=%b",
             tag, idx, c, bus.ack, bus.err, bus.mode, bus.locked);
    chk({tag, ".ack"},    32'(bus.ack), exp_ack ? 32'(bit_i) : 32'd0);
    chk({tag, ".err"},    32'(bus.err), exp_ack ? 32'd0 : 32'(bit_i));
    chk({tag, ".mode"},   32'(bus.mode), 32'(exp_mode));
    chk({tag, ".locked"}, 32'(bus.locked), 32'(exp_lock));
    bus.req[idx] = 1'b0;
    @(negedge clk);
    chk({tag, ".busy3"},  32'(bus.busy), 32'd0);
    chk({tag, ".quiet3"}, 32'(bus.ack | bus.err), 32'd0);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.cmd = '0;

    // Reset, then five idle cycles.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst.mode",   32'(bus.mode), 32'd0);
    chk("rst.locked", 32'(bus.locked), 32'd0);
    chk("rst.busy",   32'(bus.busy), 32'd0);
    chk("rst.ack",    32'(bus.ack), 32'd0);
    chk("rst.err",    32'(bus.err), 32'd0);

    // Privileged raise, then user-level moves down/up/illegal code.
    txn(0, 3'h3, 1'b1, 2'd3, 1'b0, "p0_high");
    txn(1, 3'h5, 1'b1, 2'd1, 1'b0, "u1_low");
    txn(1, 3'h3, 1'b0, 2'd1, 1'b0, "u1_escal");
    txn(1, 3'h6, 1'b1, 2'd0, 1'b0, "u1_undef");

    // Simultaneous requests with rr_ptr=0: req0 first, req1 three cycles later.
    @(negedge clk);
    bus.req    = 2'b11;
    bus.cmd    = {3'h0, 3'h5};
    @(negedge clk);
    chk("sim0.busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    $display("txn sim0 first: ack=%b err=%b mode=%0d", bus.ack, bus.err, bus.mode);
    chk("sim0.first_ack", 32'(bus.ack), 32'd1);
    chk("sim0.first_mode", 32'(bus.mode), 32'd1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("sim0.gap", 32'(bus.ack | bus.err), 32'd0);
    @(negedge clk);
    chk("sim0.gap2", 32'(bus.ack | bus.err), 32'd0);
    @(negedge clk);
    $display("txn sim0 second: ack=%b err=%b mode=%0d", bus.ack, bus.err, bus.mode);
    chk("sim0.second_ack", 32'(bus.ack), 32'd2);
    chk("sim0.second_mode", 32'(bus.mode), 32'd0);
    bus.req[1] = 1'b0;
    @(negedge clk);

    // A lone req0 moves rr_ptr to 1.
    txn(0, 3'h3, 1'b1, 2'd3, 1'b0, "p0_ptr");

    // Simultaneous with rr_ptr=1: req1 first (mode 1), then req0 (mode 2).
    @(negedge clk);
    bus.req = 2'b11;
    bus.cmd = {3'h5, 3'h4};
    @(negedge clk);
    @(negedge clk);
    $display("txn sim1 first: ack=%b err=%b mode=%0d", bus.ack, bus.err, bus.mode);
    chk("sim1.first_ack", 32'(bus.ack), 32'd2);
    chk("sim1.first_mode", 32'(bus.mode), 32'd1);
    bus.req[1] = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn sim1 second: ack=%b err=%b mode=%0d", bus.ack, bus.err, bus.mode);
    chk("sim1.second_ack", 32'(bus.ack), 32'd1);
    chk("sim1.second_mode", 32'(bus.mode), 32'd2);
    bus.req[0] = 1'b0;
    @(negedge clk);

    // Lock: user attempt rejected, privileged lock accepted, then all rejected.
    txn(1, 3'h7, 1'b0, 2'd2, 1'b0, "u1_lock");
    txn(0, 3'h7, 1'b1, 2'd2, 1'b1, "p0_lock");
    txn(0, 3'h3, 1'b0, 2'd2, 1'b1, "p0_locked");
    txn(1, 3'h0, 1'b0, 2'd2, 1'b1, "u1_locked");

    // Reset asserted while in CHECK: no pulse, state cleared at once.
    @(negedge clk);
    bus.req[0] = 1'b1;
    bus.cmd    = {3'h0, 3'h5};
    @(negedge clk);
    chk("mid.busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.mode",   32'(bus.mode), 32'd0);
    chk("mid.locked", 32'(bus.locked), 32'd0);
    chk("mid.busy",   32'(bus.busy), 32'd0);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("mid.quiet1", 32'(bus.ack | bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.quiet2", 32'(bus.ack | bus.err), 32'd0);
    chk("mid.idle",   32'(bus.busy), 32'd0);

    // Lock gone after reset; escalation rules apply again.
    txn(1, 3'h5, 1'b0, 2'd0, 1'b0, "post_u1");
    txn(0, 3'h5, 1'b1, 2'd1, 1'b0, "post_p0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_req_arbiter.md
Name: mode_req_arbiter

Overview:
Arbitrates mode-change requests from NUM_REQ requesters onto one shared 2-bit security-mode register and sequences each request through a hardened FSM. Every undefined command code and every undefined FSM encoding resolves to a defined safe outcome. Requester 0 is the privileged agent. Sits between requesting agents (debug, firmware, user logic) and the mode-gated datapath.

Parameters:
NUM_REQ, 2, number of requesters (legal range 2..4)
PRIV_IDX, 0, index of the only requester allowed to raise the mode

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level; held until the matching ack/err pulse
cmd  input  3*NUM_REQ  per-requester command code, 3 bits each, stable while req is high
ack  output  NUM_REQ  one-cycle pulse: request accepted and applied
err  output  NUM_REQ  one-cycle pulse: request rejected
mode  output  2  current security mode
locked  output  1  sticky lock flag
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async assert): mode=0, locked=0, ack=0, err=0, busy=0, rr_ptr=0, FSM=IDLE. All outputs are registered.
- Command decode (per mode_arb_pkg):
  - 3'h3 -> target mode 3
  - 3'h4 -> target mode 2
  - 3'h5 -> target mode 1
  - 3'h7 -> LOCK
  - any other code -> target mode 0 (safe default, always legal)
- FSM states: IDLE=2'b00, CHECK=2'b01, RESP=2'b10. Encoding 2'b11 is unreachable; if entered, next state is IDLE with no ack/err and no mode change.
- IDLE:
  - If any req is high, the rr_arbiter picks the winner: first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch winner index and its cmd. Set rr_ptr = (winner+1) mod NUM_REQ. Go to CHECK.
  - If no req is high, stay in IDLE and rr_ptr is unchanged.
- CHECK evaluates the latched command, in this priority order:
  - locked=1 -> reject; mode unchanged.
  - LOCK from PRIV_IDX -> locked<=1; accept. From any other requester -> reject.
  - Target > current mode and winner != PRIV_IDX -> reject (escalation denied); mode unchanged.
  - Otherwise -> mode<=target; accept.
  - In all cases go to RESP.
- RESP: ack[winner] or err[winner] is high for exactly this one cycle. Next state is IDLE.
- Latency: req sampled in IDLE at cycle N -> mode update and ack/err visible in cycle N+2 -> back in IDLE at N+3.
- Handshake:
  - Requester drops req in the cycle after its pulse.
  - A req still high when sampled in IDLE is a new request.
  - req/cmd changes while that requester is not the latched winner are ignored until the next IDLE sample.
- Simultaneous requests: only one is served per 3-cycle transaction; the others wait with req held.
- Exclusivity: at most one ack/err bit is high in any cycle, and never ack and err together.
- Lock: cleared only by rst_n.
- busy = (state != IDLE).
- Reset mid-transaction: transaction discarded, no pulse; mode returns to 0.

Decomposition:
- Package mode_arb_pkg holds:
  - state enum {IDLE, CHECK, RESP}
  - mode enum {MODE_SAFE=0, MODE_LOW=1, MODE_MID=2, MODE_HIGH=3}
  - command code constants CMD_HIGH=3'h3, CMD_MID=3'h4, CMD_LOW=3'h5, CMD_LOCK=3'h7
  - decode function cmd -> mode
- One sub-module: rr_arbiter. Combinational round-robin grant: inputs req and ptr; outputs grant_valid and grant_idx.

Test Plan:
- Reset then idle 5 cycles -> mode=0, locked=0, busy=0, no ack/err.
- Req0 cmd=3'h3 at cycle N -> busy high at N+1; mode=3 and ack[0] high at N+2 only; busy low at N+3.
- With mode=3: req1 cmd=3'h5 -> mode=1, ack[1]. Then req1 cmd=3'h3 -> err[1] and mode stays 1. Then req1 cmd=3'h6 -> mode=0, ack[1].
- req0 and req1 raised in the same cycle, held until served, rr_ptr=0 -> req0 served first (ack[0]), then req1 (pulse at 3 cycles later). Repeat with rr_ptr=1 -> req1 served first.
- Req1 cmd=3'h7 -> err[1], locked stays 0. Req0 cmd=3'h7 -> ack[0], locked=1. Then req0 cmd=3'h3 -> err[0] and mode unchanged; locked persists until rst_n.
- Assert rst_n low during CHECK -> ack/err never pulse; mode=0, locked=0, FSM=IDLE immediately.
